// File: rtl/complex_divider.sv
// Iterative fixed-point complex divider: out = a / b in signed Qm.FRAC_BITS.
// Restoring division on magnitudes, real and imaginary in parallel, saturating on overflow.
module complex_divider #(
   parameter int SIZE      = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a_real,
   input  logic [SIZE-1:0] a_complex,
   input  logic [SIZE-1:0] b_real,
   input  logic [SIZE-1:0] b_complex,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_real,
   output logic [SIZE-1:0] out_complex,
   output logic            div_zero
);

   localparam int PW = 2 * SIZE;
   localparam int NW = 2 * SIZE + 1;
   localparam int RW = 3 * SIZE + 1;
   localparam int QW = SIZE - 1;
   localparam int CW = $clog2(SIZE);

   typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   state_t state_r, next_state_s;

   logic signed [SIZE-1:0] ar_r, ai_r, br_r, bi_r;
   logic [RW-1:0] rem_re_r, rem_im_r, dsh_r;
   logic [QW-1:0] q_re_r, q_im_r;
   logic          neg_re_r, neg_im_r, ovf_re_r, ovf_im_r, dz_r;
   logic [CW-1:0] cnt_r;
   logic          in_ready_r, out_valid_r, div_zero_r;
   logic [SIZE-1:0] out_real_r, out_complex_r;

   logic signed [PW-1:0] ar_x_s, ai_x_s, br_x_s, bi_x_s;
   logic signed [PW-1:0] p_rr_s, p_ii_s, p_ir_s, p_ri_s, p_bb_r_s, p_bb_i_s;
   logic signed [NW-1:0] nr_s, ni_s;
   logic [NW-1:0] d_s, nr_mag_s, ni_mag_s;
   logic          ovf_re_s, ovf_im_s;
   logic          bit_re_s, bit_im_s;
   logic [QW-1:0] q_re_nx_s, q_im_nx_s;
   logic          in_ready_s, out_valid_s;

   // Saturating result formation from quotient magnitude and sign
   function automatic logic [SIZE-1:0] form_result(input logic dz, input logic ovf,
                                                   input logic neg, input logic [QW-1:0] q);
      logic [SIZE-1:0] r;
      if (dz) begin
         r = {1'b0, {QW{1'b1}}};
      end else if (ovf) begin
         r = neg ? {1'b1, {QW{1'b0}}} : {1'b0, {QW{1'b1}}};
      end else if (neg) begin
         r = -{1'b0, q};
      end else begin
         r = {1'b0, q};
      end
      return r;
   endfunction

   // Full-precision numerators, denominator, magnitudes and overflow detection for PREP
   always_comb begin
      ar_x_s   = PW'(ar_r);
      ai_x_s   = PW'(ai_r);
      br_x_s   = PW'(br_r);
      bi_x_s   = PW'(bi_r);
      p_rr_s   = ar_x_s * br_x_s;
      p_ii_s   = ai_x_s * bi_x_s;
      p_ir_s   = ai_x_s * br_x_s;
      p_ri_s   = ar_x_s * bi_x_s;
      p_bb_r_s = br_x_s * br_x_s;
      p_bb_i_s = bi_x_s * bi_x_s;
      nr_s     = NW'(p_rr_s) + NW'(p_ii_s);
      ni_s     = NW'(p_ir_s) - NW'(p_ri_s);
      d_s      = $unsigned(NW'(p_bb_r_s) + NW'(p_bb_i_s));
      nr_mag_s = nr_s[NW-1] ? $unsigned(-nr_s) : $unsigned(nr_s);
      ni_mag_s = ni_s[NW-1] ? $unsigned(-ni_s) : $unsigned(ni_s);
      // Quotient must fit in SIZE-1 magnitude bits
      ovf_re_s = (RW'(nr_mag_s) << FRAC_BITS) >= (RW'(d_s) << (SIZE - 1));
      ovf_im_s = (RW'(ni_mag_s) << FRAC_BITS) >= (RW'(d_s) << (SIZE - 1));
   end

   // One restoring-division step per component
   always_comb begin
      bit_re_s  = rem_re_r >= dsh_r;
      bit_im_s  = rem_im_r >= dsh_r;
      q_re_nx_s = {q_re_r[QW-2:0], bit_re_s};
      q_im_nx_s = {q_im_r[QW-2:0], bit_im_s};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = in_valid ? PREP : IDLE;
         PREP:    next_state_s = DIV;
         DIV:     next_state_s = (cnt_r == CW'(1)) ? DONE : DIV;
         DONE:    next_state_s = out_ready ? IDLE : DONE;
         default: next_state_s = IDLE;
      endcase
   end

   // Handshake outputs decoded from the upcoming state so they can be registered
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (next_state_s)
         IDLE:    in_ready_s  = 1'b1;
         DONE:    out_valid_s = 1'b1;
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // Registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= in_ready_s;
         out_valid_r <= out_valid_s;
      end
   end

   // Operand capture, preparation, iteration and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_r          <= '0;
         ai_r          <= '0;
         br_r          <= '0;
         bi_r          <= '0;
         rem_re_r      <= '0;
         rem_im_r      <= '0;
         dsh_r         <= '0;
         q_re_r        <= '0;
         q_im_r        <= '0;
         neg_re_r      <= 1'b0;
         neg_im_r      <= 1'b0;
         ovf_re_r      <= 1'b0;
         ovf_im_r      <= 1'b0;
         dz_r          <= 1'b0;
         cnt_r         <= '0;
         out_real_r    <= '0;
         out_complex_r <= '0;
         div_zero_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  ar_r <= a_real;
                  ai_r <= a_complex;
                  br_r <= b_real;
                  bi_r <= b_complex;
               end
            end
            PREP: begin
               rem_re_r <= RW'(nr_mag_s) << FRAC_BITS;
               rem_im_r <= RW'(ni_mag_s) << FRAC_BITS;
               dsh_r    <= RW'(d_s) << (SIZE - 2);
               q_re_r   <= '0;
               q_im_r   <= '0;
               neg_re_r <= nr_s[NW-1];
               neg_im_r <= ni_s[NW-1];
               ovf_re_r <= ovf_re_s;
               ovf_im_r <= ovf_im_s;
               dz_r     <= (d_s == NW'(0));
               cnt_r    <= CW'(SIZE - 1);
            end
            DIV: begin
               if (!dz_r) begin
                  rem_re_r <= bit_re_s ? rem_re_r - dsh_r : rem_re_r;
                  rem_im_r <= bit_im_s ? rem_im_r - dsh_r : rem_im_r;
                  q_re_r   <= q_re_nx_s;
                  q_im_r   <= q_im_nx_s;
               end
               dsh_r <= dsh_r >> 1;
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  out_real_r    <= form_result(dz_r, ovf_re_r, neg_re_r, q_re_nx_s);
                  out_complex_r <= form_result(dz_r, ovf_im_r, neg_im_r, q_im_nx_s);
                  div_zero_r    <= dz_r;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign out_real    = out_real_r;
   assign out_complex = out_complex_r;
   assign div_zero    = div_zero_r;

endmodule
